// File: rtl/apb_pkg.sv
// Shared definitions for the APB memory slave: FSM encoding, wait-state
// limit and the bit positions inside PPROT.
package apb_pkg;

   // Transfer FSM: IDLE waits for a setup cycle, ACCESS runs the wait states.
   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } apb_state_e;

   // The wait counter is 3 bits wide, so at most 7 wait states.
   localparam int APB_WAIT_MAX = 7;

   // PPROT bit positions (the slave accepts protection info but does not act on it).
   localparam int PPROT_PRIV_BIT   = 0;
   localparam int PPROT_NONSEC_BIT = 1;
   localparam int PPROT_INSTR_BIT  = 2;

endpackage

// File: rtl/apb_mem_ram.sv
// Word-organised storage with per-byte write enables and an asynchronous
// read port. Contents are deliberately left out of reset.
module apb_mem_ram
   import apb_pkg::*;
#(
   parameter int P_DEPTH  = 16,
   parameter int P_DWIDTH = 32,
   parameter int P_STRB   = P_DWIDTH / 8,
   parameter int P_AW     = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1
) (
   input  logic                clk,
   input  logic                we,
   input  logic [P_STRB-1:0]   be,
   input  logic [P_AW-1:0]     waddr,
   input  logic [P_DWIDTH-1:0] wdata,
   input  logic [P_AW-1:0]     raddr,
   output logic [P_DWIDTH-1:0] rdata
);

   logic [P_DWIDTH-1:0] mem_q [P_DEPTH];

   // Byte-lane write: only lanes with their enable set take new data.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < P_STRB; i++) begin
            if (be[i]) begin
               mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_mem_slave.sv
// APB memory slave: decodes a 64 KiB window selected by PADDR[31:16],
// inserts a fixed number of wait states and serves a small word memory.
// Everything the transfer needs is captured in the setup cycle, so bus
// changes during wait states are harmless.
module apb_mem_slave
   import apb_pkg::*;
#(
   parameter int          P_DWIDTH     = 32,
   parameter int          P_STRB       = P_DWIDTH / 8,
   parameter logic [15:0] P_ADDR_START = 16'h0000,
   parameter int          P_DEPTH      = 16,
   parameter int          P_WAIT       = 0
) (
   input  logic                PCLK,
   input  logic                PRESET,
   input  logic                PSEL,
   input  logic [31:0]         PADDR,
   input  logic                PENABLE,
   input  logic                PWRITE,
   input  logic [P_DWIDTH-1:0] PWDATA,
   input  logic [P_STRB-1:0]   PSTRB,
   input  logic [2:0]          PPROT,
   output logic [P_DWIDTH-1:0] PRDATA,
   output logic                PREADY,
   output logic                PSLVERR
);

   localparam int         AW     = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
   localparam logic [2:0] WAIT_C = (P_WAIT > APB_WAIT_MAX) ? 3'(APB_WAIT_MAX) : 3'(P_WAIT);

   apb_state_e          state_q,   state_d;
   logic [2:0]          cnt_q,     cnt_d;
   logic [AW-1:0]       addr_q,    addr_d;
   logic                write_q,   write_d;
   logic                err_q,     err_d;
   logic [P_DWIDTH-1:0] wdata_q,   wdata_d;
   logic [P_STRB-1:0]   strb_q,    strb_d;
   logic                pready_q,  pready_d;
   logic                pslverr_q, pslverr_d;
   logic [P_DWIDTH-1:0] prdata_q,  prdata_d;

   logic                setup_err;
   logic [AW-1:0]       setup_idx;
   logic [AW-1:0]       ram_raddr;
   logic [P_DWIDTH-1:0] ram_rdata;
   logic                ram_we;
   logic                unused_pprot;

   // Protection attributes are accepted but have no effect on this slave.
   assign unused_pprot = PPROT[PPROT_PRIV_BIT] ^ PPROT[PPROT_NONSEC_BIT] ^ PPROT[PPROT_INSTR_BIT];

   // Out-of-window, beyond-depth and unaligned addresses are all errors.
   assign setup_err = (PADDR[31:16] != P_ADDR_START)
                   || ({18'd0, PADDR[15:2]} >= 32'(P_DEPTH))
                   || (PADDR[1:0] != 2'b00);
   assign setup_idx = PADDR[AW+1:2];

   // With zero wait states the read data is loaded during setup, so the
   // read port looks at the live bus address while idle.
   assign ram_raddr = (state_q == ST_IDLE) ? setup_idx : addr_q;

   // Memory is written only on a clean completion edge of a write.
   assign ram_we = (state_q == ST_ACCESS) && PSEL && PENABLE && pready_q && write_q && !err_q;

   // Next-state and next-output logic for the transfer FSM.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      write_d   = write_q;
      err_d     = err_q;
      wdata_d   = wdata_q;
      strb_d    = strb_q;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      prdata_d  = '0;
      case (state_q)
         ST_IDLE: begin
            // PENABLE without a preceding setup cycle is ignored here.
            if (PSEL && !PENABLE) begin
               state_d = ST_ACCESS;
               cnt_d   = 3'd0;
               addr_d  = setup_idx;
               write_d = PWRITE;
               err_d   = setup_err;
               wdata_d = PWDATA;
               strb_d  = PSTRB;
               if (WAIT_C == 3'd0) begin
                  pready_d  = 1'b1;
                  pslverr_d = setup_err;
                  prdata_d  = (!PWRITE && !setup_err) ? ram_rdata : '0;
               end
            end
         end
         ST_ACCESS: begin
            if (!PSEL) begin
               // Master dropped select: abandon the transfer without writing.
               state_d = ST_IDLE;
            end else if (PENABLE && pready_q) begin
               state_d = ST_IDLE;
            end else if (PENABLE) begin
               cnt_d = cnt_q + 3'd1;
               if (cnt_q + 3'd1 == WAIT_C) begin
                  pready_d  = 1'b1;
                  pslverr_d = err_q;
                  prdata_d  = (!write_q && !err_q) ? ram_rdata : '0;
               end
            end else begin
               // Select held without enable: stall with outputs unchanged.
               pready_d  = pready_q;
               pslverr_d = pslverr_q;
               prdata_d  = prdata_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and registered outputs; reset discards any transfer in flight.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 3'd0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         err_q     <= 1'b0;
         wdata_q   <= '0;
         strb_q    <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         write_q   <= write_d;
         err_q     <= err_d;
         wdata_q   <= wdata_d;
         strb_q    <= strb_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
      end
   end

   apb_mem_ram #(
      .P_DEPTH  (P_DEPTH),
      .P_DWIDTH (P_DWIDTH),
      .P_STRB   (P_STRB),
      .P_AW     (AW)
   ) u_ram (
      .clk   (PCLK),
      .we    (ram_we),
      .be    (strb_q),
      .waddr (addr_q),
      .wdata (wdata_q),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   assign PRDATA  = prdata_q;
   assign PREADY  = pready_q;
   assign PSLVERR = pslverr_q;

endmodule

// File: doc/apb_mem_slave.md
APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

Interface
REQ-001 SHALL have parameter P_DWIDTH, default 32: data width; only 32 is supported.
REQ-002 SHALL have parameter P_STRB, default P_DWIDTH/8: byte-strobe width.
REQ-003 SHALL have parameter P_ADDR_START, default 16'h0000: value PADDR[31:16] must match.
REQ-004 SHALL have parameter P_DEPTH, default 16: memory depth in words.
REQ-005 SHALL have parameter P_WAIT, default 0: wait states per transfer, range 0..7.
REQ-006 SHALL have port PCLK, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port PRESET, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have port PSEL, input, 1: slave select.
REQ-009 SHALL have port PADDR, input, 32: byte address.
REQ-010 SHALL have port PENABLE, input, 1: access phase.
REQ-011 SHALL have port PWRITE, input, 1: 1 = write, 0 = read.
REQ-012 SHALL have port PWDATA, input, P_DWIDTH: write data.
REQ-013 SHALL have port PSTRB, input, P_STRB: write byte lanes.
REQ-014 SHALL have port PPROT, input, 3: accepted and ignored.
REQ-015 SHALL have port PRDATA, output, P_DWIDTH: read data.
REQ-016 SHALL have port PREADY, output, 1: transfer completes.
REQ-017 SHALL have port PSLVERR, output, 1: error; meaningful only while PREADY=1.

Function
REQ-018 SHALL implement FSM IDLE -> ACCESS -> IDLE with a wait counter of 3 bits.
REQ-019 IDLE: the cycle with PSEL=1 & PENABLE=0 is the setup cycle; it SHALL register the address, direction and error status, clear the counter, and move to ACCESS.
REQ-020 ACCESS: PREADY SHALL be 1 exactly in the access cycle where counter==P_WAIT, so P_WAIT=0 completes in the first access cycle; PREADY SHALL be 0 in all other cycles.
REQ-021 ACCESS with PSEL=1 & PENABLE=1 & PREADY=0: the counter SHALL increment.
REQ-022 Completion edge (PSEL & PENABLE & PREADY): state SHALL return to IDLE; a new setup SHALL be accepted in the very next cycle (back-to-back).
REQ-023 Error condition: PADDR[31:16]!=P_ADDR_START, or word index PADDR[15:2] >= P_DEPTH, or PADDR[1:0]!=0.
REQ-024 On error: PSLVERR=1 together with PREADY, PRDATA=0, and memory unchanged.
REQ-025 Error-free write: on the completion edge each byte lane i with PSTRB[i]=1 SHALL take PWDATA byte i; other lanes unchanged; PSTRB=0 is a legal no-op.
REQ-026 Error-free read: PRDATA SHALL hold the addressed word during the PREADY=1 cycle and 0 in all other cycles; PSTRB is ignored.
REQ-027 PENABLE=1 while in IDLE (no setup) SHALL be ignored: no transfer, PREADY stays 0.
REQ-028 PSEL=0 while in ACCESS SHALL abort the transfer: return to IDLE with no write.
REQ-029 PADDR, PWRITE or PWDATA changing during wait states SHALL have no effect; the setup-cycle capture rules.
REQ-030 Memory contents SHALL persist across transfers and SHALL NOT be reset.

Reset
REQ-031 PRESET=1 SHALL asynchronously force IDLE, counter=0, PREADY=0, PSLVERR=0, PRDATA=0.
REQ-032 Reset asserted mid-transfer SHALL discard the transfer: no memory write.
REQ-033 Operation SHALL resume on the first setup cycle after PRESET deasserts.

Structure
REQ-034 The shared package apb_pkg SHALL hold the FSM state encoding, the P_WAIT maximum (7), and the PPROT bit constants.
REQ-035 Storage SHALL be a sub-module apb_mem_ram: P_DEPTH x P_DWIDTH, byte-write-enable, combinational read.

Verification
REQ-036 P_WAIT=0: write 0xDEADBEEF to 0x0000_0004 with PSTRB=4'hF, then read it back -> each transfer has PREADY in its first access cycle, PRDATA=0xDEADBEEF, PSLVERR=0.
REQ-037 P_WAIT=3: read 0x0000_0008 -> PREADY is 0 for 3 access cycles and 1 in the 4th.
REQ-038 Word 0x0 holds 0x11223344; write 0xAABBCCDD with PSTRB=4'b0101 -> read returns 0x11BB33DD.
REQ-039 Write to 0x0001_0000, 0x0000_0040 and 0x0000_0002 -> each gives PSLVERR=1 with PREADY; reading all 16 valid words afterwards shows no change.
REQ-040 PRESET pulsed during the wait states of a write of 0x12345678 to 0x0 -> outputs go to 0 immediately and a later read of 0x0 returns the old value.
REQ-041 Write 16 random words back-to-back, then read all 16 back-to-back -> every read matches, with no idle cycle required between transfers.
